im_loader: RTL



---
 rtl/im_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// im_loader: boot-time instruction memory writer.
// Consumes a length-prefixed, XOR-checksummed byte stream, assembles
// little-endian 32-bit words, writes them to consecutive word addresses and
// holds the core in reset until the image is loaded and verified.
module im_loader #(
  parameter int unsigned ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 we,
  output logic [ADDR_BITS-1:0] waddr,
  output logic [31:0]          wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CNT_W = ADDR_BITS + 1;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [23:0]          shift_q, shift_d;
  logic [7:0]           csum_q, csum_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 xfer;
  logic [15:0]          len_n;
  logic                 last_word;

  // Handshake, full word count as seen on the LEN_HI byte, and last-word detect
  assign xfer      = rx_valid && rx_ready_q;
  assign len_n     = {rx_data, len_q[7:0]};
  assign last_word = (16'(cnt_q) + 16'd1) == len_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LEN0;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0: if (xfer) state_d = S_LEN1;
      S_LEN1: begin
        if (xfer) begin
          if (32'(len_n) > DEPTH) state_d = S_ERR;
          else if (len_n == 16'd0) state_d = S_CSUM;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: if (xfer && idx_q == 2'd3 && last_word) state_d = S_CSUM;
      S_CSUM: if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LEN0: if (xfer) len_d[7:0] = rx_data;
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          cnt_d       = '0;
          idx_d       = 2'd0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0: shift_d[7:0]   = rx_data;
            2'd1: shift_d[15:8]  = rx_data;
            2'd2: shift_d[23:16] = rx_data;
            default: begin
              we_d    = 1'b1;
              waddr_d = cnt_q[ADDR_BITS-1:0];
              wdata_d = {rx_data, shift_q};
              cnt_d   = cnt_q + CNT_W'(1);
            end
          endcase
        end
      end
      default: ;
    endcase
    rx_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      shift_q    <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
